kbd_scancode_decoder: RTL and testbench
=======================================

// Module: kbd_scancode_decoder
// PURPOSE
//  Sits directly downstream of the PS/2 AXI-Stream keyboard front-end. Consumes the
//  raw Set-2 scancode byte stream, runs the E0/F0 prefix state machine and keeps a
//  held/released flag per game key. Gives the game core level outputs (left/right/
//  fire) and one-cycle press pulses (fire/start). Typematic repeats are suppressed.
// PARAMETERS
//  AXIS_DATA_WIDTH  8          slave TDATA width; only bits [7:0] are decoded
//  PREFIX_TIMEOUT   2_500_000  cycles allowed after E0/F0 before the prefix is dropped (50 ms @ 50 MHz)
//  CODE_LEFT_EXT    8'h6B      left arrow (E0-prefixed)
//  CODE_RIGHT_EXT   8'h74      right arrow (E0-prefixed)
//  CODE_LEFT_ALT    8'h1C      'A' key (no prefix)
//  CODE_RIGHT_ALT   8'h23      'D' key (no prefix)
//  CODE_FIRE        8'h29      space (no prefix)
//  CODE_START       8'h5A      Enter (no prefix; E0 5A keypad-Enter is ignored)
// PORTS
//  axis_aclk_i      in   1   clock
//  axis_aresetn_i   in   1   asynchronous active-low reset
//  s_axis_tvalid_i  in   1   scancode byte valid
//  s_axis_tready_o  out  1   ready to accept a byte
//  s_axis_tdata_i   in   AXIS_DATA_WIDTH  scancode byte
//  key_left_o       out  1   level: left arrow OR 'A' held
//  key_right_o      out  1   level: right arrow OR 'D' held
//  key_fire_o       out  1   level: space held
//  fire_pulse_o     out  1   1-cycle pulse on the space make edge
//  start_pulse_o    out  1   1-cycle pulse on the Enter make edge
// BEHAVIOUR
//  Reset: all outputs 0, all held bits 0, state IDLE, timeout counter 0.
//  s_axis_tready_o: registered. 0 while reset is asserted. 1 from the first clock edge
//   after reset release, then held at 1 (one byte accepted per cycle).
//  A byte is consumed on each cycle where tvalid & tready. Consumed bytes are b below.
//  FSM states IDLE, EXT, BRK, EXT_BRK:
//   IDLE:    b=E0 -> EXT; b=F0 -> BRK; otherwise make(b, ext=0), stay IDLE.
//   EXT:     b=F0 -> EXT_BRK; b=E0 -> stay EXT; otherwise make(b, ext=1) -> IDLE.
//   BRK:     b=E0 or F0 -> protocol error, discard -> IDLE; otherwise break(b, ext=0) -> IDLE.
//   EXT_BRK: b=E0 or F0 -> discard -> IDLE; otherwise break(b, ext=1) -> IDLE.
//   Any state, b=00 or FF (keyboard error/overrun): clear all held bits -> IDLE.
//   Error bytes take priority over every rule above.
//   Codes not in the map only advance the FSM and have no other effect.
//  Held bits: left_arrow, left_a, right_arrow, right_d, fire, start.
//   make sets the matching bit; break clears it.
//   key_left_o  = left_arrow | left_a
//   key_right_o = right_arrow | right_d
//   key_fire_o  = fire
//  Pulses: fire_pulse_o / start_pulse_o assert for exactly 1 cycle, only when a make
//   arrives for a key whose held bit was 0. Repeated makes while held produce no pulse.
//  Latency: all outputs are registered and update on the clock edge that consumes the
//   final byte of a sequence, so they are visible the following cycle.
//  Timeout: the counter runs while the state is not IDLE and clears on every consumed
//   byte. When it reaches PREFIX_TIMEOUT-1, the state returns to IDLE and held bits
//   are left unchanged. Counter width is $clog2(PREFIX_TIMEOUT).
//  Left and right both held: both outputs are 1. Arbitration belongs to the game core.
//  Reset mid-sequence (e.g. after E0): the partial sequence is lost and the block
//   returns to IDLE with all outputs cleared.
// TESTING
//  1. Reset release, then send 29 -> key_fire_o=1 and fire_pulse_o high for 1 cycle;
//     send 29 29 -> no further pulse; send F0 29 -> key_fire_o=0.
//  2. Send E0 6B -> key_left_o=1; send 1C -> stays 1; send F0 1C -> still 1;
//     send E0 F0 6B -> key_left_o=0.
//  3. Send E0 74 then FF -> key_right_o=0 and FSM in IDLE; next 23 -> key_right_o=1.
//  4. With PREFIX_TIMEOUT=16: send E0, idle 20 cycles, send 74 -> key_right_o stays 0
//     (non-extended 74 is unmapped); send E0 5A -> start_pulse_o stays 0.
//  5. Back-to-back tvalid every cycle: 5A F0 5A 5A -> exactly two start pulses, one
//     cycle after the first and fourth bytes.
//  6. Assert reset after E0 F0 with key_left_o=1 -> all outputs 0 and tready 0; after
//     release, send 6B -> key_left_o=0 (the prefix was lost).

Source files
------------

// File: rtl/kbd_scancode_decoder.sv
// kbd_scancode_decoder: PS/2 Set-2 scancode decoder for the game core.
// Tracks E0/F0 prefixes and held keys; drives level outputs and make pulses. Rev 1.0
`default_nettype none

module kbd_scancode_decoder #(
  parameter int          AXIS_DATA_WIDTH = 8,
  parameter int          PREFIX_TIMEOUT  = 2_500_000,
  parameter logic [7:0]  CODE_LEFT_EXT   = 8'h6B,
  parameter logic [7:0]  CODE_RIGHT_EXT  = 8'h74,
  parameter logic [7:0]  CODE_LEFT_ALT   = 8'h1C,
  parameter logic [7:0]  CODE_RIGHT_ALT  = 8'h23,
  parameter logic [7:0]  CODE_FIRE       = 8'h29,
  parameter logic [7:0]  CODE_START      = 8'h5A
) (
  input  logic                       axis_aclk_i,
  input  logic                       axis_aresetn_i,
  input  logic                       s_axis_tvalid_i,
  output logic                       s_axis_tready_o,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                       key_left_o,
  output logic                       key_right_o,
  output logic                       key_fire_o,
  output logic                       fire_pulse_o,
  output logic                       start_pulse_o
);

  localparam int CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] BYTE_EXT  = 8'hE0;
  localparam logic [7:0] BYTE_BRK  = 8'hF0;
  localparam logic [7:0] BYTE_ERR0 = 8'h00;
  localparam logic [7:0] BYTE_ERR1 = 8'hFF;

  localparam int H_LEFT_ARROW  = 0;
  localparam int H_LEFT_A      = 1;
  localparam int H_RIGHT_ARROW = 2;
  localparam int H_RIGHT_D     = 3;
  localparam int H_FIRE        = 4;
  localparam int H_START       = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       held_q, held_d;
  logic             tready_q, tready_d;
  logic             key_left_q, key_left_d;
  logic             key_right_q, key_right_d;
  logic             key_fire_q, key_fire_d;
  logic             fire_pulse_q, fire_pulse_d;
  logic             start_pulse_q, start_pulse_d;

  logic [7:0] rx_byte;
  logic       byte_acc;
  logic       ext_ctx;
  logic       is_prefix;
  logic       is_error;
  logic       is_make;
  logic       is_break;
  logic [5:0] key_sel;

  assign rx_byte   = s_axis_tdata_i[7:0];
  assign byte_acc  = s_axis_tvalid_i & tready_q;
  assign ext_ctx   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign is_prefix = (rx_byte == BYTE_EXT) || (rx_byte == BYTE_BRK);
  assign is_error  = (rx_byte == BYTE_ERR0) || (rx_byte == BYTE_ERR1);

  // Extended and plain codes share byte values, so the map depends on the prefix context.
  always_comb begin
    key_sel = '0;
    if (ext_ctx) begin
      key_sel[H_LEFT_ARROW]  = (rx_byte == CODE_LEFT_EXT);
      key_sel[H_RIGHT_ARROW] = (rx_byte == CODE_RIGHT_EXT);
    end else begin
      key_sel[H_LEFT_A]  = (rx_byte == CODE_LEFT_ALT);
      key_sel[H_RIGHT_D] = (rx_byte == CODE_RIGHT_ALT);
      key_sel[H_FIRE]    = (rx_byte == CODE_FIRE);
      key_sel[H_START]   = (rx_byte == CODE_START);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    held_d        = held_q;
    tready_d      = 1'b1;
    fire_pulse_d  = 1'b0;
    start_pulse_d = 1'b0;
    is_make       = 1'b0;
    is_break      = 1'b0;

    if (byte_acc) begin
      cnt_d = '0;
      if (is_error) begin
        held_d  = '0;
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_byte == BYTE_EXT) begin
              state_d = ST_EXT;
            end else if (rx_byte == BYTE_BRK) begin
              state_d = ST_BRK;
            end else begin
              is_make = 1'b1;
            end
          end
          ST_EXT: begin
            if (rx_byte == BYTE_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (rx_byte != BYTE_EXT) begin
              is_make = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            is_break = ~is_prefix;
            state_d  = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is abandoned without touching the held keys.
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end

    if (is_make) begin
      held_d        = held_q | key_sel;
      fire_pulse_d  = key_sel[H_FIRE] & ~held_q[H_FIRE];
      start_pulse_d = key_sel[H_START] & ~held_q[H_START];
    end else if (is_break) begin
      held_d = held_q & ~key_sel;
    end

    key_left_d  = held_d[H_LEFT_ARROW] | held_d[H_LEFT_A];
    key_right_d = held_d[H_RIGHT_ARROW] | held_d[H_RIGHT_D];
    key_fire_d  = held_d[H_FIRE];
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      held_q        <= '0;
      tready_q      <= 1'b0;
      key_left_q    <= 1'b0;
      key_right_q   <= 1'b0;
      key_fire_q    <= 1'b0;
      fire_pulse_q  <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      held_q        <= held_d;
      tready_q      <= tready_d;
      key_left_q    <= key_left_d;
      key_right_q   <= key_right_d;
      key_fire_q    <= key_fire_d;
      fire_pulse_q  <= fire_pulse_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign key_left_o      = key_left_q;
  assign key_right_o     = key_right_q;
  assign key_fire_o      = key_fire_q;
  assign fire_pulse_o    = fire_pulse_q;
  assign start_pulse_o   = start_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_kbd_scancode_decoder.sv
// tb_kbd_scancode_decoder: directed and random scancode streams against a key-table model.
// Rev 1.0
`default_nettype none

module tb_kbd_scancode_decoder;

  localparam int PT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tready, key_left, key_right, key_fire, fire_pulse, start_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: set of held keys, pending prefix flags, idle cycles since last byte.
  bit [5:0] m_held;
  bit       m_ext, m_brk, m_ready, m_fp, m_sp;
  int       m_idle;

  wire [5:0] obs   = {tready, key_left, key_right, key_fire, fire_pulse, start_pulse};
  wire [5:0] exp_v = {m_ready, m_held[0] | m_held[1], m_held[2] | m_held[3], m_held[4], m_fp, m_sp};

  kbd_scancode_decoder #(
    .AXIS_DATA_WIDTH (8),
    .PREFIX_TIMEOUT  (PT)
  ) dut (
    .axis_aclk_i     (clk),
    .axis_aresetn_i  (rst_n),
    .s_axis_tvalid_i (tvalid),
    .s_axis_tready_o (tready),
    .s_axis_tdata_i  (tdata),
    .key_left_o      (key_left),
    .key_right_o     (key_right),
    .key_fire_o      (key_fire),
    .fire_pulse_o    (fire_pulse),
    .start_pulse_o   (start_pulse)
  );

  always #5 clk = ~clk;

  // Key table: 0 left arrow, 1 'A', 2 right arrow, 3 'D', 4 space, 5 Enter.
  function automatic int key_idx(input logic [7:0] b, input bit e);
    if (e) begin
      if (b == 8'h6B) return 0;
      if (b == 8'h74) return 2;
    end else begin
      if (b == 8'h1C) return 1;
      if (b == 8'h23) return 3;
      if (b == 8'h29) return 4;
      if (b == 8'h5A) return 5;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_held = '0; m_ext = 0; m_brk = 0; m_ready = 0; m_fp = 0; m_sp = 0; m_idle = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    m_idle = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      m_held = '0; m_ext = 0; m_brk = 0;
    end else if (!m_brk && b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_brk && b == 8'hE0) begin
      m_ext = 1;
    end else if (m_brk && (b == 8'hE0 || b == 8'hF0)) begin
      m_ext = 0; m_brk = 0;
    end else begin
      k = key_idx(b, m_ext);
      if (k >= 0) begin
        if (m_brk) begin
          m_held[k] = 1'b0;
        end else begin
          if (k == 4 && !m_held[4]) m_fp = 1;
          if (k == 5 && !m_held[5]) m_sp = 1;
          m_held[k] = 1'b1;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // One clock: present inputs, advance the model at the edge, land on the falling edge.
  task automatic step(input bit v, input logic [7:0] b);
    bit acc;
    tvalid = v;
    tdata  = b;
    @(posedge clk);
    acc  = v && m_ready && rst_n;
    m_fp = 0;
    m_sp = 0;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (acc) begin
        model_byte(b);
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle >= PT) begin
          m_ext = 0; m_brk = 0; m_idle = 0;
        end
      end
      m_ready = 1;
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h29);
      vectors++;
      if (obs !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold obs=%b exp=%b", obs, 6'b0);
      end
    end
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    vectors++;
    if (obs !== 6'b100000 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 6'b100000);
    end
  endtask

  task automatic test_fire();
    logic [7:0] seq [6] = '{8'h29, 8'h00_29 == 0 ? 8'h29 : 8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
    int pulses = 0;
    seq[1] = 8'h29;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i]);
      if (i == 0) step(1'b0, 8'h00);
      pulses += fire_pulse;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL fire_seq[%0d] obs=%b exp=%b", i, obs, exp_v);
      end
    end
    vectors++;
    if (pulses != 0 || key_fire !== 1'b0) begin
      miscompares++;
      $display("FAIL fire_repeat pulses_after_first=%0d key_fire=%b exp 0/0", pulses, key_fire);
    end
  endtask

  task automatic test_left();
    logic [7:0] seq [8] = '{8'hE0, 8'h6B, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h6B};
    bit       want [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i]);
      vectors++;
      if (obs !== exp_v || key_left !== want[i]) begin
        miscompares++;
        $display("FAIL left_seq[%0d] obs=%b exp=%b key_left_req=%b", i, obs, exp_v, want[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] seq [4] = '{8'hE0, 8'h74, 8'hFF, 8'h23};
    bit       want [4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i]);
      vectors++;
      if (obs !== exp_v || key_right !== want[i]) begin
        miscompares++;
        $display("FAIL error_seq[%0d] obs=%b exp=%b key_right_req=%b", i, obs, exp_v, want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    step(1'b1, 8'hF0);
    step(1'b1, 8'h23);
    // Prefix dropped after a long gap, then kept with one idle cycle less than the limit.
    step(1'b1, 8'hE0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h74);
    vectors++;
    if (key_right !== 1'b0 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL timeout_drop obs=%b exp=%b key_right_req=0", obs, exp_v);
    end
    step(1'b1, 8'hE0);
    step(1'b1, 8'h5A);
    vectors++;
    if (start_pulse !== 1'b0 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL ext_enter obs=%b exp=%b start_pulse_req=0", obs, exp_v);
    end
    step(1'b1, 8'hE0);
    for (int i = 0; i < PT - 1; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h74);
    vectors++;
    if (key_right !== 1'b1 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL timeout_edge_keep obs=%b exp=%b key_right_req=1", obs, exp_v);
    end
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    for (int i = 0; i < PT; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h74);
    vectors++;
    if (key_right !== 1'b1 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL timeout_edge_drop obs=%b exp=%b key_right_req=1", obs, exp_v);
    end
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h74);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4] = '{8'h5A, 8'hF0, 8'h5A, 8'h5A};
    logic [3:0] seen = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i]);
      seen[i] = start_pulse;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_seq[%0d] obs=%b exp=%b", i, obs, exp_v);
      end
    end
    vectors++;
    if (seen !== 4'b1001) begin
      miscompares++;
      $display("FAIL b2b_pulses got=%b required=%b", seen, 4'b1001);
    end
    step(1'b1, 8'hF0);
    step(1'b1, 8'h5A);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hE0);
    step(1'b1, 8'h6B);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    vectors++;
    if (key_left !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre key_left=%b required=1", key_left);
    end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async obs=%b required=%b", obs, 6'b0);
    end
    @(negedge clk);
    step(1'b1, 8'h6B);
    rst_n = 1'b1;
    step(1'b1, 8'h6B);
    step(1'b1, 8'h6B);
    vectors++;
    if (key_left !== 1'b0 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_mid_lost obs=%b exp=%b key_left_req=0", obs, exp_v);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23,
                              8'h29, 8'h5A, 8'h00, 8'hFF, 8'hF0, 8'hE0};
    logic [7:0] b;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int g = 0; g < int'($urandom_range(PT - 3, PT + 2)); g++) step(1'b0, 8'h00);
      end
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else                           b = pool[$urandom_range(0, 11)];
      step($urandom_range(0, 3) != 0, b);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random[%0d] byte=%h obs=%b exp=%b", i, b, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_left();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
